// File: rtl/chip8_alu_pkg.sv
// Opcode and FSM state definitions for the sequential Chip8 ALU.
// Shared with the CPU decode stage.
package chip8_alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OR  = 4'd0,
        AND = 4'd1,
        XOR = 4'd2,
        ADD = 4'd3,
        SUB = 4'd4,
        SHL = 4'd5,
        SHR = 4'd6,
        EQ  = 4'd7,
        GT  = 4'd8,
        INC = 4'd9,
        BCD = 4'd10
    } alu_op_t;

    typedef enum logic {
        IDLE    = 1'b0,
        BCD_RUN = 1'b1
    } alu_state_t;

endpackage

// File: rtl/chip8_bcd_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift the
// whole {digits, binary} register left by one bit.
module chip8_bcd_step #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BCD_DIGITS = 3
) (
    input  logic [4*BCD_DIGITS+WIDTH-1:0] sh_in,
    output logic [4*BCD_DIGITS+WIDTH-1:0] sh_out_c
);

    localparam int unsigned SH_W = 4*BCD_DIGITS + WIDTH;

    logic [SH_W-1:0] fixed;

    always_comb begin
        fixed = sh_in;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (sh_in[WIDTH+4*i +: 4] >= 4'd5) begin
                fixed[WIDTH+4*i +: 4] = sh_in[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        // The top digit cannot overflow once the digit count is large enough.
        sh_out_c = SH_W'({fixed, 1'b0});
    end

endmodule

// File: rtl/chip8_alu_seq.sv
// Handshaked Chip8 ALU: single-cycle ops register result/carry (VF) under
// valid/ready, FX33 BCD runs iteratively over WIDTH cycles.
module chip8_alu_seq
    import chip8_alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         op,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        result,
    output logic                    carry,
    output logic [4*BCD_DIGITS-1:0] bcd_out,
    output logic                    busy
);

    localparam int unsigned BCD_W = 4*BCD_DIGITS;
    localparam int unsigned SH_W  = BCD_W + WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH+1);

    if (WIDTH < 2) begin : g_width_check
        $error("chip8_alu_seq: WIDTH must be at least 2");
    end
    if ((64'd10 ** BCD_DIGITS) < (64'd1 << WIDTH)) begin : g_digits_check
        $error("chip8_alu_seq: BCD_DIGITS too small to hold 2**WIDTH-1");
    end

    alu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SH_W-1:0]    sh_q, sh_d, sh_step_c;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   alu_res_c;
    logic               alu_cy_c;
    logic [WIDTH:0]     sum_c;

    chip8_bcd_step #(
        .WIDTH      (WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bcd_step (
        .sh_in    (sh_q),
        .sh_out_c (sh_step_c)
    );

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign bcd_out   = bcd_q;
    assign busy      = busy_q;

    // Single-cycle operation datapath.
    always_comb begin
        alu_res_c = '0;
        alu_cy_c  = 1'b0;
        sum_c     = {1'b0, a} + {1'b0, b};
        case (alu_op_t'(op))
            OR:  alu_res_c = a | b;
            AND: alu_res_c = a & b;
            XOR: alu_res_c = a ^ b;
            ADD: begin
                alu_res_c = sum_c[WIDTH-1:0];
                alu_cy_c  = sum_c[WIDTH];
            end
            SUB: begin
                alu_res_c = a - b;
                alu_cy_c  = (a >= b);
            end
            SHL: begin
                alu_res_c = {a[WIDTH-2:0], 1'b0};
                alu_cy_c  = a[WIDTH-1];
            end
            SHR: begin
                alu_res_c = {1'b0, a[WIDTH-1:1]};
                alu_cy_c  = a[0];
            end
            EQ:  alu_res_c = WIDTH'(a == b);
            GT:  alu_res_c = WIDTH'(a > b);
            INC: begin
                alu_res_c = a + WIDTH'(1);
                alu_cy_c  = &a;
            end
            default: begin
                alu_res_c = '0;
                alu_cy_c  = 1'b0;
            end
        endcase
    end

    // Handshake and BCD iteration control.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sh_d        = sh_q;
        a_d         = a_q;
        result_d    = result_q;
        carry_d     = carry_q;
        bcd_d       = bcd_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (in_valid && in_ready) begin
                    if (op == OP_W'(BCD)) begin
                        state_d = BCD_RUN;
                        sh_d    = SH_W'(a);
                        a_d     = a;
                        count_d = '0;
                        busy_d  = 1'b1;
                    end else begin
                        result_d    = alu_res_c;
                        carry_d     = alu_cy_c;
                        bcd_d       = '0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            BCD_RUN: begin
                sh_d    = sh_step_c;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH-1)) begin
                    bcd_d       = sh_step_c[SH_W-1 -: BCD_W];
                    result_d    = a_q;
                    carry_d     = 1'b0;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            sh_q        <= '0;
            a_q         <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sh_q        <= sh_d;
            a_q         <= a_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_chip8_alu_seq.sv
// Bench for chip8_alu_seq: an 8-bit and a 16-bit instance checked against a
// cycle-level reference model every cycle, plus directed literal expectations.
module tb_chip8_alu_seq;
    import chip8_alu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic        iv  [2];
    logic        orr [2];
    logic [3:0]  opv [2];
    logic [15:0] av  [2];
    logic [15:0] bv  [2];
    logic        ir  [2];
    logic        ov  [2];
    logic        cy  [2];
    logic        bz  [2];
    logic [7:0]  r8;
    logic [15:0] r16;
    logic [11:0] bc8;
    logic [19:0] bc16;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int last_waits;

    // Reference model state
    logic        m_valid [2];
    logic        m_busy  [2];
    int          m_cnt   [2];
    logic [15:0] m_a     [2];
    logic [15:0] m_res   [2];
    logic        m_cy    [2];
    logic [19:0] m_bcd   [2];

    alu_op_t     s_op  [4] = '{OR, AND, GT, INC};
    logic [15:0] s_a   [4] = '{16'h00F0, 16'h00F0, 16'h0005, 16'h00FF};
    logic [15:0] s_b   [4] = '{16'h000F, 16'h003C, 16'h0003, 16'h0000};
    logic [15:0] s_res [4] = '{16'h00FF, 16'h0030, 16'h0001, 16'h0000};
    logic        s_cy  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    chip8_alu_seq #(.WIDTH(8), .BCD_DIGITS(3)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .op(opv[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .result(r8), .carry(cy[0]), .bcd_out(bc8), .busy(bz[0])
    );

    chip8_alu_seq #(.WIDTH(16), .BCD_DIGITS(5)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .op(opv[1]),
        .a(av[1]), .b(bv[1]), .out_valid(ov[1]), .out_ready(orr[1]),
        .result(r16), .carry(cy[1]), .bcd_out(bc16), .busy(bz[1])
    );

    function automatic logic [15:0] dut_res(input int i);
        return (i == 0) ? 16'(r8) : r16;
    endfunction

    function automatic logic [19:0] dut_bcd(input int i);
        return (i == 0) ? 20'(bc8) : bc16;
    endfunction

    function automatic int unsigned wmask(input int i);
        return (i == 0) ? 32'h00FF : 32'hFFFF;
    endfunction

    // {carry, result} from the arithmetic definition of each op
    function automatic logic [16:0] ref_alu(input int i, input logic [3:0] op,
                                            input logic [15:0] a, input logic [15:0] b);
        int unsigned x, y, m, w, r;
        logic c;
        x = 32'(a) & wmask(i);
        y = 32'(b) & wmask(i);
        m = wmask(i);
        w = (i == 0) ? 8 : 16;
        c = 1'b0;
        case (op)
            4'd0:    r = x | y;
            4'd1:    r = x & y;
            4'd2:    r = x ^ y;
            4'd3:    begin r = (x + y) & m; c = (x + y) > m; end
            4'd4:    begin r = (x - y) & m; c = (x >= y); end
            4'd5:    begin r = (x << 1) & m; c = ((x >> (w - 1)) & 1) == 1; end
            4'd6:    begin r = x >> 1; c = (x & 1) == 1; end
            4'd7:    r = (x == y) ? 1 : 0;
            4'd8:    r = (x > y) ? 1 : 0;
            4'd9:    begin r = (x + 1) & m; c = (x == m); end
            default: r = 0;
        endcase
        return {c, 16'(r)};
    endfunction

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] d;
        int unsigned t;
        d = '0;
        t = v;
        for (int k = 0; k < 5; k++) begin
            d[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return d;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", name, i, act, exp, $time);
        end
    endtask

    // Cycle-level reference model of the handshake and op semantics
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_valid[i] <= 1'b0;
                m_busy[i]  <= 1'b0;
                m_cnt[i]   <= 0;
                m_a[i]     <= '0;
                m_res[i]   <= '0;
                m_cy[i]    <= 1'b0;
                m_bcd[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i]) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_busy[i]  <= 1'b0;
                        m_valid[i] <= 1'b1;
                        m_res[i]   <= m_a[i];
                        m_cy[i]    <= 1'b0;
                        m_bcd[i]   <= to_bcd(32'(m_a[i]));
                    end
                end else begin
                    if (m_valid[i] && orr[i]) m_valid[i] <= 1'b0;
                    if (iv[i] && (!m_valid[i] || orr[i])) begin
                        if (opv[i] == 4'd10) begin
                            m_busy[i] <= 1'b1;
                            m_cnt[i]  <= (i == 0) ? 8 : 16;
                            m_a[i]    <= 16'(32'(av[i]) & wmask(i));
                        end else begin
                            m_valid[i]           <= 1'b1;
                            {m_cy[i], m_res[i]}  <= ref_alu(i, opv[i], av[i], bv[i]);
                            m_bcd[i]             <= '0;
                        end
                    end
                end
            end
        end
    end

    // Compare DUT against model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("m_in_ready", i, 32'(ir[i]), 32'(!m_busy[i] && (!m_valid[i] || orr[i])));
                chk("m_out_valid", i, 32'(ov[i]), 32'(m_valid[i]));
                chk("m_busy", i, 32'(bz[i]), 32'(m_busy[i]));
                if (m_valid[i]) begin
                    chk("m_result", i, 32'(dut_res(i)), 32'(m_res[i]));
                    chk("m_carry", i, 32'(cy[i]), 32'(m_cy[i]));
                    chk("m_bcd", i, 32'(dut_bcd(i)), 32'(m_bcd[i]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op, wait (bounded) for in_ready, and return after the accepting edge
    task automatic issue(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int n;
        iv[i]  = 1'b1;
        opv[i] = op;
        av[i]  = a;
        bv[i]  = b;
        #1;
        n = 0;
        while (!ir[i] && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        last_waits = n;
        if (!ir[i]) chk("issue_timeout", i, 32'(n), 32'(0));
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            iv[i]  = 1'b0;
            orr[i] = 1'b1;
            opv[i] = '0;
            av[i]  = '0;
            bv[i]  = '0;
        end
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_out_valid", i, 32'(ov[i]), 0);
            chk("rst_result", i, 32'(dut_res(i)), 0);
            chk("rst_carry", i, 32'(cy[i]), 0);
            chk("rst_bcd", i, 32'(dut_bcd(i)), 0);
            chk("rst_busy", i, 32'(bz[i]), 0);
            chk("rst_in_ready", i, 32'(ir[i]), 1);
        end
        tick();
        reset = 1'b0;
        tick();

        // ADD overflow, visible one edge after accept
        issue(0, ADD, 16'h00F0, 16'h0020);
        chk("add_valid", 0, 32'(ov[0]), 1);
        chk("add_res", 0, 32'(r8), 32'h10);
        chk("add_cy", 0, 32'(cy[0]), 1);

        issue(0, SUB, 16'h0005, 16'h0007);
        chk("sub_borrow_res", 0, 32'(r8), 32'hFE);
        chk("sub_borrow_cy", 0, 32'(cy[0]), 0);
        issue(0, SUB, 16'h0007, 16'h0005);
        chk("sub_res", 0, 32'(r8), 32'h02);
        chk("sub_cy", 0, 32'(cy[0]), 1);
        issue(0, SHL, 16'h0081, 16'h0000);
        chk("shl_res", 0, 32'(r8), 32'h02);
        chk("shl_cy", 0, 32'(cy[0]), 1);
        issue(0, SHR, 16'h0081, 16'h0000);
        chk("shr_res", 0, 32'(r8), 32'h40);
        chk("shr_cy", 0, 32'(cy[0]), 1);

        // BCD 255: busy for 8 edges
        issue(0, BCD, 16'd255, 16'h0000);
        chk("bcd_busy0", 0, 32'(bz[0]), 1);
        chk("bcd_in_ready0", 0, 32'(ir[0]), 0);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("bcd_busy_run", 0, 32'(bz[0]), 1);
            chk("bcd_valid_run", 0, 32'(ov[0]), 0);
        end
        tick();
        chk("bcd_done_valid", 0, 32'(ov[0]), 1);
        chk("bcd_done_busy", 0, 32'(bz[0]), 0);
        chk("bcd_255", 0, 32'(bc8), 32'h255);
        chk("bcd_result", 0, 32'(r8), 32'hFF);
        tick();

        // Backpressure hold, then retire+accept and a full-rate stream
        orr[0] = 1'b0;
        issue(0, XOR, 16'h00AA, 16'h000F);
        chk("xor_res", 0, 32'(r8), 32'hA5);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_res", 0, 32'(r8), 32'hA5);
            chk("hold_in_ready", 0, 32'(ir[0]), 0);
        end
        orr[0] = 1'b1;
        issue(0, ADD, 16'h0001, 16'h0002);
        chk("retire_accept_stall", 0, 32'(last_waits), 0);
        chk("retire_accept_res", 0, 32'(r8), 32'h03);
        for (int k = 0; k < 4; k++) begin
            issue(0, s_op[k], s_a[k], s_b[k]);
            chk("stream_stall", 0, 32'(last_waits), 0);
            chk("stream_res", 0, 32'(r8), 32'(s_res[k]));
            chk("stream_cy", 0, 32'(cy[0]), 32'(s_cy[k]));
        end
        issue(0, 4'hF, 16'h00FF, 16'h00FF);
        chk("illegal_res", 0, 32'(r8), 0);
        chk("illegal_cy", 0, 32'(cy[0]), 0);
        tick();

        // Asynchronous reset in the middle of a BCD run
        issue(0, BCD, 16'd199, 16'h0000);
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("abort_valid", 0, 32'(ov[0]), 0);
        chk("abort_busy", 0, 32'(bz[0]), 0);
        chk("abort_bcd", 0, 32'(bc8), 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 0, 32'(ir[0]), 1);
        issue(0, EQ, 16'h003C, 16'h003C);
        chk("eq_res", 0, 32'(r8), 32'h01);
        chk("eq_cy", 0, 32'(cy[0]), 0);
        issue(0, GT, 16'h003C, 16'h003C);
        chk("gt_equal_res", 0, 32'(r8), 0);
        tick();

        // 16-bit instance
        issue(1, BCD, 16'hFFFF, 16'h0000);
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("bcd16_busy", 1, 32'(bz[1]), 1);
        end
        tick();
        chk("bcd16_valid", 1, 32'(ov[1]), 1);
        chk("bcd16_65535", 1, 32'(bc16), 32'h65535);
        chk("bcd16_result", 1, 32'(r16), 32'hFFFF);
        issue(1, INC, 16'hFFFF, 16'h0000);
        chk("inc16_res", 1, 32'(r16), 0);
        chk("inc16_cy", 1, 32'(cy[1]), 1);
        chk("inc16_bcd_clear", 1, 32'(bc16), 0);
        issue(1, SHL, 16'h8000, 16'h0000);
        chk("shl16_res", 1, 32'(r16), 0);
        chk("shl16_cy", 1, 32'(cy[1]), 1);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
